tour_cmd_responder: RTL
=======================

Name: tour_cmd_responder

Overview:
- Far-end responder for the cmd / cmd_rdy / clr_cmd_rdy / send_resp move-command handshake; sits where cmd_proc sits.
- Used as a fast executor model during integration and as a tour recorder.
- Accepts vertical/horizontal move commands, emulates execution time, and tracks the knight position on the 5x5 board.
- Re-encodes each horizontal+vertical command pair back into the 8-bit one-hot move code and logs it in a 24-entry move memory.

Parameters:
- SQ_CYCLES, 16, clock cycles of emulated execution per square moved (must be >= 1).
- LOG_DEPTH, 24, number of move-log entries; tour is complete at LOG_DEPTH moves.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- cmd  in  16  command: [15:12] opcode, [11:4] heading, [3:0] squares.
- cmd_rdy  in  1  command valid.
- clr_cmd_rdy  out  1  command accepted, one-cycle pulse.
- send_resp  out  1  command complete, one-cycle pulse.
- load  in  1  synchronous initialise.
- start_x  in  3  initial x.
- start_y  in  3  initial y.
- x_pos  out  3  current x, 0..4.
- y_pos  out  3  current y, 0..4.
- rd_indx  in  5  move-log read address.
- rd_move  out  8  log[rd_indx], combinational read.
- mv_cnt  out  5  moves logged.
- tour_done  out  1  mv_cnt == LOG_DEPTH.
- err_illegal  out  1  sticky protocol/move error.
- err_revisit  out  1  sticky revisit error (optional feature).

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - State IDLE; clr_cmd_rdy=0, send_resp=0.
  - x_pos=0, y_pos=0, mv_cnt=0, tour_done=0, err_illegal=0, err_revisit=0.
  - Pair register empty.
  - Log contents undefined.
- Opcodes:
  - 4'b0010 = vertical. Heading 8'h00 = +y, 8'h7F = -y.
  - 4'b0011 = horizontal. Heading 8'hBF = +x, 8'h3F = -x.
  - Any other opcode, or an unlisted heading, is a non-move: handshake and timing only, no position/log effect, no error.
- State machine IDLE -> ACCEPT -> EXEC -> RESP -> IDLE:
  - IDLE: when cmd_rdy=1 at an edge, latch cmd and go to ACCEPT.
  - ACCEPT: clr_cmd_rdy=1 for exactly this cycle. Go to EXEC, load the down-counter with squares*SQ_CYCLES (8-bit squares*width product). If the product is 0, go directly to RESP.
  - EXEC: decrement each cycle; go to RESP when the count reaches 1.
  - RESP: send_resp=1 for one cycle; apply the position/pair update; go to IDLE.
- Latency: with cmd_rdy sampled at cycle 0, clr_cmd_rdy is high in cycle 1 and send_resp in cycle 2+squares*SQ_CYCLES.
- cmd_rdy is ignored outside IDLE. cmd_rdy still high on return to IDLE starts a new command; no inherent gap is required.
- Move update in RESP:
  - Squares must be 1 or 2. Otherwise set err_illegal, clear the pair register, leave position unchanged.
  - The target must be in 0..4. Otherwise set err_illegal, leave position unchanged, clear the pair register.
  - On a legal target, position is updated immediately.
  - A pair is one horizontal plus one vertical command, in either order.
  - A second command on the same axis while the pair is half-full sets err_illegal and discards the old half; the new command becomes the first half.
- Pair completion:
  - Encode signed (dx,dy): bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1).
  - |dx|==|dy| sets err_illegal; the move is not logged.
  - Otherwise write log[mv_cnt] and increment mv_cnt. Pair clears either way.
  - When mv_cnt==LOG_DEPTH: tour_done=1, further pairs are not logged, mv_cnt saturates, and err_illegal is set.
- load (any state, highest priority):
  - x_pos/y_pos <= start_x/start_y. start values > 4 clamp to 4.
  - mv_cnt=0, errors cleared, pair cleared, state <= IDLE.
  - An in-flight command is aborted; no send_resp is issued for it.
- rd_indx >= LOG_DEPTH returns 8'h00.

Optional Feature:
- Macro VISIT_CHK_EN.
- Defined:
  - 25-bit visited map; the square set by load is marked visited.
  - Each completed logged pair marks its landing square.
  - Landing on an already-visited square sets sticky err_revisit; the move is still logged.
  - load clears the map.
- Undefined: no map; err_revisit tied 0.

Test Plan:
- Reset, then check outputs -> all outputs 0, state IDLE; cmd_rdy=1 with cmd=16'h3BF1, SQ_CYCLES=16 -> clr_cmd_rdy in cycle 1, send_resp in cycle 18 only.
- load start (2,2); send 16'h3BF1 then 16'h2002 -> x_pos=3, y_pos=4, log[0]=8'h02, mv_cnt=1.
- load (0,0); send 16'h33F1 (west) -> err_illegal=1, x_pos=0, no log write, send_resp still pulses.
- Two vertical commands 16'h2001, 16'h2001 back-to-back -> err_illegal=1, mv_cnt unchanged; then 16'h3BF2 -> pair (+2,+1)? no, |dx|=2,|dy|=1 -> log 8'h80.
- 24 legal pairs followed by a 25th -> tour_done=1 after the 24th, mv_cnt=24, 25th not logged, err_illegal=1.
- load asserted during EXEC of 16'h2002 -> no send_resp, state IDLE next cycle; with VISIT_CHK_EN, a revisit of (2,2) sets err_revisit=1.

Source files
------------

// File: rtl/tour_cmd_responder_if.sv
// Move-command handshake between a command source (master) and the responder (slave).
interface tour_cmd_responder_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;

  modport master (output cmd, cmd_rdy, input clr_cmd_rdy, send_resp);
  modport slave  (input cmd, cmd_rdy, output clr_cmd_rdy, send_resp);
endinterface

// File: rtl/tour_cmd_responder.sv
// Far-end move-command responder: emulates execution, tracks the knight, logs re-encoded moves; VISIT_CHK_EN adds revisit detection.
// Latency: clr_cmd_rdy one cycle after cmd_rdy is taken, send_resp 2+squares*SQ_CYCLES cycles after; cmd_rdy is held off (ignored) until IDLE.
module tour_cmd_responder #(
  parameter int SQ_CYCLES = 16,
  parameter int LOG_DEPTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tour_cmd_responder_if.slave      bus,
  input  logic                     load,
  input  logic [2:0]               start_x,
  input  logic [2:0]               start_y,
  output logic [2:0]               x_pos,
  output logic [2:0]               y_pos,
  input  logic [4:0]               rd_indx,
  output logic [7:0]               rd_move,
  output logic [4:0]               mv_cnt,
  output logic                     tour_done,
  output logic                     err_illegal,
  output logic                     err_revisit
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCEPT = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  localparam logic [4:0] DEPTH5 = 5'(LOG_DEPTH);

  logic [1:0]        state;
  logic [15:0]       cmd_q;
  logic [7:0]        cnt;
  logic [7:0]        prod;
  logic              pair_vld;
  logic              pair_is_h;
  logic signed [2:0] pair_d;
  logic [7:0]        log_mem [LOG_DEPTH];

  logic [3:0]        opc;
  logic [7:0]        hd;
  logic [3:0]        sq;
  logic              is_v, is_h, is_mv, neg, sq_ok, in_rng;
  logic [2:0]        mag, cur;
  logic signed [2:0] d, dx, dy;
  logic [3:0]        tgt;
  logic [7:0]        code;
  logic              resp_act, mv_ok, pair_done, log_we;
  logic [2:0]        clamp_x, clamp_y;

  assign opc   = cmd_q[15:12];
  assign hd    = cmd_q[11:4];
  assign sq    = cmd_q[3:0];
  assign is_v  = (opc == 4'b0010) && ((hd == 8'h00) || (hd == 8'h7F));
  assign is_h  = (opc == 4'b0011) && ((hd == 8'hBF) || (hd == 8'h3F));
  assign is_mv = is_v || is_h;
  assign neg   = is_h ? (hd == 8'h3F) : (hd == 8'h7F);
  assign sq_ok = (sq == 4'd1) || (sq == 4'd2);
  assign mag   = {1'b0, sq[1:0]};
  assign d     = neg ? -$signed(mag) : $signed(mag);
  assign cur   = is_h ? x_pos : y_pos;
  // 4-bit wrap makes a negative target land above 4, so one compare covers both edges
  assign tgt    = {1'b0, cur} + {d[2], d};
  assign in_rng = (tgt <= 4'd4);
  assign dx     = is_h ? d : pair_d;
  assign dy     = is_h ? pair_d : d;
  assign prod   = 8'(int'(sq) * SQ_CYCLES);

  // Non-knight deltas (|dx|==|dy|) fall through to zero
  always_comb begin
    code = 8'h00;
    case ({dx, dy})
      6'b111_010: code = 8'h01;
      6'b001_010: code = 8'h02;
      6'b110_001: code = 8'h04;
      6'b110_111: code = 8'h08;
      6'b111_110: code = 8'h10;
      6'b001_110: code = 8'h20;
      6'b010_111: code = 8'h40;
      6'b010_001: code = 8'h80;
      default:    code = 8'h00;
    endcase
  end

  assign resp_act  = (state == RESP) && !load;
  assign mv_ok     = resp_act && is_mv && sq_ok && in_rng;
  assign pair_done = mv_ok && pair_vld && (pair_is_h != is_h);
  assign log_we    = pair_done && (code != 8'h00) && !tour_done;

  assign clamp_x   = (start_x > 3'd4) ? 3'd4 : start_x;
  assign clamp_y   = (start_y > 3'd4) ? 3'd4 : start_y;

  assign bus.clr_cmd_rdy = (state == ACCEPT);
  assign bus.send_resp   = resp_act;
  assign tour_done       = (mv_cnt == DEPTH5);
  assign rd_move         = (rd_indx < DEPTH5) ? log_mem[rd_indx] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_q       <= 16'h0000;
      cnt         <= 8'h00;
      x_pos       <= 3'd0;
      y_pos       <= 3'd0;
      mv_cnt      <= 5'd0;
      err_illegal <= 1'b0;
      pair_vld    <= 1'b0;
      pair_is_h   <= 1'b0;
      pair_d      <= 3'sd0;
    end else if (load) begin
      state       <= IDLE;
      x_pos       <= clamp_x;
      y_pos       <= clamp_y;
      mv_cnt      <= 5'd0;
      err_illegal <= 1'b0;
      pair_vld    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_rdy) begin
          cmd_q <= bus.cmd;
          state <= ACCEPT;
        end
        ACCEPT: begin
          cnt   <= prod;
          state <= (prod == 8'h00) ? RESP : EXEC;
        end
        EXEC: if (cnt <= 8'd1) state <= RESP;
              else             cnt   <= cnt - 8'd1;
        RESP: begin
          state <= IDLE;
          if (is_mv) begin
            if (!sq_ok || !in_rng) begin
              err_illegal <= 1'b1;
              pair_vld    <= 1'b0;
            end else begin
              if (is_h) x_pos <= tgt[2:0];
              else      y_pos <= tgt[2:0];
              if (pair_done) begin
                pair_vld <= 1'b0;
                if ((code == 8'h00) || tour_done) err_illegal <= 1'b1;
                else                              mv_cnt      <= mv_cnt + 5'd1;
              end else begin
                // Same-axis repeat replaces the stale half
                if (pair_vld) err_illegal <= 1'b1;
                pair_vld  <= 1'b1;
                pair_is_h <= is_h;
                pair_d    <= d;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (log_we) log_mem[mv_cnt] <= code;
  end

`ifdef VISIT_CHK_EN
  logic [24:0] visited;
  logic [2:0]  nx, ny;
  logic [4:0]  land_idx, start_idx;

  assign nx        = is_h ? tgt[2:0] : x_pos;
  assign ny        = is_h ? y_pos : tgt[2:0];
  assign land_idx  = 5'(ny) * 5'd5 + 5'(nx);
  assign start_idx = 5'(clamp_y) * 5'd5 + 5'(clamp_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visited     <= 25'd0;
      err_revisit <= 1'b0;
    end else if (load) begin
      visited     <= 25'd1 << start_idx;
      err_revisit <= 1'b0;
    end else if (log_we) begin
      if (visited[land_idx]) err_revisit <= 1'b1;
      visited[land_idx] <= 1'b1;
    end
  end
`else
  assign err_revisit = 1'b0;
`endif

endmodule
